// File: rtl/buffer_loader.sv
// Fetches one buffer's worth of memory words, packs them into tiles and
// writes each tile into buffer_file.
module buffer_loader #(
    parameter int BUFFER_WIDTH   = 1024,
    parameter int BUFFER_COUNT   = 2,
    parameter int TILE_WIDTH     = 256,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH     = 24,
    localparam int BUF_W = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [BUF_W-1:0]          buf_id,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
    output logic                      write_enable,
    output logic [TILE_WIDTH-1:0]     write_data,
    output logic [BUF_W-1:0]          write_buffer
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | issuing requests / collecting responses for the current tile
    // WRITE | one-cycle tile write strobe to buffer_file
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    localparam int TILE_COUNT     = BUFFER_WIDTH / TILE_WIDTH;
    localparam int WORDS_PER_TILE = TILE_WIDTH / MEM_DATA_WIDTH;
    localparam int BYTES_PER_WORD = MEM_DATA_WIDTH / 8;
    localparam int CNT_W          = $clog2(WORDS_PER_TILE + 1);
    localparam int IDX_W          = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [BUF_W-1:0]        buf_q;
    logic [IDX_W-1:0]        tile_idx;
    logic [CNT_W-1:0]        issued;
    logic [CNT_W-1:0]        received;
    logic [TILE_WIDTH-1:0]   tile;
    logic [TILE_WIDTH-1:0]   tile_next;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic                    accept;
    logic                    capture;
    logic                    last_word;

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign write_enable = (state == WRITE);
    assign write_buffer = buf_q;
    assign mem_req      = (state == FETCH) && (issued < CNT_W'(WORDS_PER_TILE));
    assign accept       = mem_req && mem_ready;
    // a response with nothing outstanding is stray and must not advance the tile
    assign capture      = (state == FETCH) && mem_rvalid && (received != issued);
    assign last_word    = capture && (received == CNT_W'(WORDS_PER_TILE - 1));

    always_comb begin
        word_idx = ADDR_WIDTH'(tile_idx) * ADDR_WIDTH'(WORDS_PER_TILE) + ADDR_WIDTH'(issued);
        mem_addr = '0;
        if (state == FETCH)
            mem_addr = base_q + word_idx * ADDR_WIDTH'(BYTES_PER_WORD);
    end

    always_comb begin
        tile_next = tile;
        if (capture)
            tile_next[int'(received) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            base_q     <= '0;
            buf_q      <= '0;
            tile_idx   <= '0;
            issued     <= '0;
            received   <= '0;
            tile       <= '0;
            write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        buf_q    <= buf_id;
                        tile_idx <= '0;
                        issued   <= '0;
                        received <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (accept)
                        issued <= issued + CNT_W'(1);
                    if (capture) begin
                        tile     <= tile_next;
                        received <= received + CNT_W'(1);
                    end
                    // write_data is a separate register so it holds between writes
                    if (last_word) begin
                        write_data <= tile_next;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    issued   <= '0;
                    received <= '0;
                    if (tile_idx == IDX_W'(TILE_COUNT - 1)) begin
                        state <= DONE;
                    end else begin
                        tile_idx <= tile_idx + IDX_W'(1);
                        state    <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
